// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: RV32I/RV64I major
// opcodes, sequencer state encoding, fault codes and the opcode class record
// produced by the classifier.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE         = 2'b00,
        FC_ILLEGAL      = 2'b01,
        FC_IMEM_TIMEOUT = 2'b10,
        FC_DMEM_TIMEOUT = 2'b11
    } fault_code_t;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_system;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_opcode_classifier.sv
// Combinational opcode classifier.
//   opcode   in  7  major opcode (IR[6:0])
//   op_class out    {is_load, is_store, is_branch, is_system, illegal}
// RV64 selects whether the 32-bit word ops (OP-32, OP-IMM-32) are legal.
module multicycle_control_unit_opcode_classifier
    import multicycle_control_unit_pkg::*;
#(
    parameter bit RV64 = 1'b1
) (
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        unique case (opcode)
            OP_LOAD:   op_class.is_load   = 1'b1;
            OP_STORE:  op_class.is_store  = 1'b1;
            OP_BRANCH: op_class.is_branch = 1'b1;
            OP_SYSTEM: op_class.is_system = 1'b1;
            OP_MISC_MEM, OP_OP_IMM, OP_AUIPC, OP_OP, OP_LUI,
            OP_JALR, OP_JAL: ;
            OP_OP_32, OP_OP_IMM_32: op_class.illegal = !RV64;
            default:   op_class.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK)
// with ready handshakes, per-access timeout, start/halt control, fault
// reporting and retired/cycle counters.
//   clk, reset                      clock, synchronous active-high reset
//   start, halt_req                 run control (levels)
//   opcode                          IR[6:0], valid from DECODE onward
//   imem_ready, dmem_ready          memory handshakes
//   imem_req, ir_write_en           fetch request / IR latch pulse
//   dm_req, dm_write_en             data access request / store
//   rf_write_en, pc_write_en        writeback / retire pulses
//   busy, halted, fault, fault_code status
//   retired, cycles                 wrapping counters
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | imem_req high, waiting for imem_ready
// DECODE    | classify opcode; SYSTEM halts, illegal faults
// EXECUTE   | route to MEMORY / retire (branch) / WRITEBACK
// MEMORY    | dm_req high, waiting for dmem_ready
// WRITEBACK | rf_write_en, retire
// HALT      | stopped, sticky until reset
// FAULT     | stopped with fault_code, sticky until reset
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int INSTRUCTION_SIZE = 32,
    parameter bit RV64             = 1'b1,
    parameter int TIMEOUT_CYCLES   = 16,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [6:0]           opcode,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write_en,
    output logic                 dm_req,
    output logic                 dm_write_en,
    output logic                 rf_write_en,
    output logic                 pc_write_en,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [CNT_WIDTH-1:0] cycles
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    if (TIMEOUT_CYCLES < 1 || INSTRUCTION_SIZE < 7) begin : g_param_check
        $error("multicycle_control_unit: TIMEOUT_CYCLES must be >= 1 and INSTRUCTION_SIZE >= 7");
    end

    state_t      state, next_state;
    fault_code_t fault_q, fault_nxt;
    op_class_t   op_class;
    logic [TMR_W-1:0] tmr_q;
    logic        timed_out;
    logic        retire;
    logic        count_retire;

    multicycle_control_unit_opcode_classifier #(.RV64(RV64)) u_classifier (
        .opcode   (opcode),
        .op_class (op_class)
    );

    assign timed_out = (tmr_q == '0);

    always_comb begin
        next_state   = state;
        fault_nxt    = FC_NONE;
        retire       = 1'b0;
        count_retire = 1'b0;
        unique case (state)
            ST_IDLE:   if (start) next_state = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    next_state = ST_DECODE;
                end else if (timed_out) begin
                    next_state = ST_FAULT;
                    fault_nxt  = FC_IMEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (op_class.is_system) begin
                    // ECALL/EBREAK stops the core; it counts as retired but
                    // the PC is left pointing at it.
                    next_state   = ST_HALT;
                    count_retire = 1'b1;
                end else if (op_class.illegal) begin
                    next_state = ST_FAULT;
                    fault_nxt  = FC_ILLEGAL;
                end else begin
                    next_state = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (op_class.is_load || op_class.is_store) next_state = ST_MEMORY;
                else if (op_class.is_branch)                retire     = 1'b1;
                else                                        next_state = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (dmem_ready) begin
                    if (op_class.is_store) retire     = 1'b1;
                    else                   next_state = ST_WRITEBACK;
                end else if (timed_out) begin
                    next_state = ST_FAULT;
                    fault_nxt  = FC_DMEM_TIMEOUT;
                end
            end
            ST_WRITEBACK: retire = 1'b1;
            ST_HALT, ST_FAULT: ;
            default:   next_state = ST_IDLE;
        endcase
        // halt_req is only looked at on an instruction boundary.
        if (retire) begin
            count_retire = 1'b1;
            next_state   = halt_req ? ST_HALT : ST_FETCH;
        end
    end

    always_comb begin
        imem_req    = (state == ST_FETCH);
        ir_write_en = (state == ST_FETCH) && imem_ready;
        dm_req      = (state == ST_MEMORY);
        dm_write_en = (state == ST_MEMORY) && op_class.is_store;
        rf_write_en = (state == ST_WRITEBACK);
        pc_write_en = retire;
        busy        = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_FAULT);
        halted      = (state == ST_HALT);
        fault       = (state == ST_FAULT);
        fault_code  = fault_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            fault_q <= FC_NONE;
            tmr_q   <= '0;
            retired <= '0;
            cycles  <= '0;
        end else begin
            state <= next_state;
            if (next_state == ST_FAULT && state != ST_FAULT) fault_q <= fault_nxt;
            // Wait timer reloads on every state change so each FETCH/MEMORY
            // entry gets a fresh budget of TIMEOUT_CYCLES waiting cycles.
            if (next_state != state)  tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
            else if (!timed_out)      tmr_q <= tmr_q - 1'b1;
            if (count_retire) retired <= retired + CNT_WIDTH'(1);
            if (busy)         cycles  <= cycles + CNT_WIDTH'(1);
        end
    end

endmodule
